// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: digit patterns {g,f,e,d,c,b,a} and the
// encoder state type.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam int ACC_W = 10;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

endpackage

// File: rtl/seg7_to_digit.sv
// Combinational decoder from a seven-segment pattern to a BCD digit, with
// flags for a recognised digit and for the blank pattern.
module seg7_to_digit
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic       o_isDigit,
    output logic       o_isBlank,
    output logic [3:0] o_digit
);

    always_comb begin
        o_isDigit = 1'b1;
        o_isBlank = 1'b0;
        o_digit   = 4'd0;
        case (i_seg)
            SEG_0:     o_digit = 4'd0;
            SEG_1:     o_digit = 4'd1;
            SEG_2:     o_digit = 4'd2;
            SEG_3:     o_digit = 4'd3;
            SEG_4:     o_digit = 4'd4;
            SEG_5:     o_digit = 4'd5;
            SEG_6:     o_digit = 4'd6;
            SEG_7:     o_digit = 4'd7;
            SEG_8:     o_digit = 4'd8;
            SEG_9:     o_digit = 4'd9;
            SEG_BLANK: begin
                o_isDigit = 1'b0;
                o_isBlank = 1'b1;
            end
            default:   o_isDigit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_to_binary_encoder.sv
// Accumulates a most-significant-first stream of seven-segment digits into an
// 8-bit binary result with code and range error flags, valid/ready on both sides.
module seg_to_binary_encoder
    import seg7_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    input  logic       seg_valid,
    input  logic       seg_last,
    output logic       seg_ready,
    output logic [7:0] bin,
    output logic       err_code,
    output logic       err_range,
    output logic       bin_valid,
    input  logic       bin_ready
);

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [2:0]         r_count;
    logic               r_errCode;
    logic               r_seenDigit;
    logic               r_segReady;
    logic               r_binValid;
    logic [7:0]         r_bin;
    logic               r_errCodeOut;
    logic               r_errRangeOut;

    logic               w_isDigit;
    logic               w_isBlank;
    logic [3:0]         w_digit;
    logic               w_xfer;
    logic [3:0]         w_digitVal;
    logic [13:0]        w_mul;
    logic [ACC_W-1:0]   w_mulSat;
    logic [ACC_W:0]     w_sum;
    logic [ACC_W-1:0]   w_accNext;
    logic               w_codeErrNow;
    logic               w_rangeFinal;

    seg7_to_digit u_decode (
        .i_seg     (seg_in),
        .o_isDigit (w_isDigit),
        .o_isBlank (w_isBlank),
        .o_digit   (w_digit)
    );

    // Both the x10 step and the digit add saturate at 1023 so an oversized
    // number can never wrap back into the legal 0..255 window.
    assign w_xfer       = seg_valid && r_segReady;
    assign w_digitVal   = w_isDigit ? w_digit : 4'd0;
    assign w_mul        = {4'b0000, r_acc} * 14'd10;
    assign w_mulSat     = (w_mul > 14'd1023) ? 10'd1023 : w_mul[ACC_W-1:0];
    assign w_sum        = {1'b0, w_mulSat} + {7'b0000000, w_digitVal};
    assign w_accNext    = w_sum[ACC_W] ? 10'd1023 : w_sum[ACC_W-1:0];
    assign w_codeErrNow = (!w_isDigit && !w_isBlank) || (w_isBlank && r_seenDigit);
    assign w_rangeFinal = (r_count > 3'd3) || (r_acc > 10'd255);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ACCUM;
            r_acc         <= '0;
            r_count       <= '0;
            r_errCode     <= 1'b0;
            r_seenDigit   <= 1'b0;
            r_segReady    <= 1'b0;
            r_binValid    <= 1'b0;
            r_bin         <= '0;
            r_errCodeOut  <= 1'b0;
            r_errRangeOut <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    r_segReady <= 1'b1;
                    if (w_xfer) begin
                        r_acc       <= w_accNext;
                        r_count     <= (r_count == 3'd4) ? 3'd4 : r_count + 3'd1;
                        r_errCode   <= r_errCode || w_codeErrNow;
                        r_seenDigit <= r_seenDigit || w_isDigit;
                        if (seg_last) begin
                            r_state    <= DONE;
                            r_segReady <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the result; afterwards it is
                    // frozen until the consumer takes it.
                    if (!r_binValid) begin
                        r_binValid    <= 1'b1;
                        r_errCodeOut  <= r_errCode;
                        r_errRangeOut <= w_rangeFinal;
                        r_bin         <= (r_errCode || w_rangeFinal) ? 8'h00 : r_acc[7:0];
                    end else if (bin_ready) begin
                        r_state       <= ACCUM;
                        r_segReady    <= 1'b1;
                        r_binValid    <= 1'b0;
                        r_bin         <= '0;
                        r_errCodeOut  <= 1'b0;
                        r_errRangeOut <= 1'b0;
                        r_acc         <= '0;
                        r_count       <= '0;
                        r_errCode     <= 1'b0;
                        r_seenDigit   <= 1'b0;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign seg_ready = r_segReady;
    assign bin_valid = r_binValid;
    assign bin       = r_bin;
    assign err_code  = r_errCodeOut;
    assign err_range = r_errRangeOut;

endmodule

// File: tb/tb_seg_to_binary_encoder.sv
// Directed and randomised-gap bench for seg_to_binary_encoder; each scenario
// task drives its own digits and checks the results it expects.
module tb_seg_to_binary_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_in = 7'h00;
    logic       seg_valid = 1'b0;
    logic       seg_last = 1'b0;
    logic       seg_ready;
    logic [7:0] bin;
    logic       err_code;
    logic       err_range;
    logic       bin_valid;
    logic       bin_ready = 1'b0;

    int errors = 0;
    int checks = 0;
    int gapMax = 0;
    logic [6:0] vec [4];
    logic [6:0] segTab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    seg_to_binary_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .seg_valid (seg_valid),
        .seg_last  (seg_last),
        .seg_ready (seg_ready),
        .bin       (bin),
        .err_code  (err_code),
        .err_range (err_range),
        .bin_valid (bin_valid),
        .bin_ready (bin_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic sendDigit(input logic [6:0] pat, input logic last);
        int guard;
        guard = 0;
        seg_in    = pat;
        seg_last  = last;
        seg_valid = 1'b1;
        while (seg_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checks++; errors++;
            $display("[TB] FAIL sendTimeout: seg_ready=%b, required 1", seg_ready);
        end
        @(posedge clk); #1;
        seg_valid = 1'b0;
        seg_last  = 1'b0;
        seg_in    = 7'h00;
    endtask

    task automatic sendNumber(input int n);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = int'($urandom_range(0, gapMax));
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
            sendDigit(vec[i], (i == n - 1));
        end
    endtask

    task automatic waitValid(output int waited);
        waited = 0;
        while (bin_valid !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
    endtask

    task automatic ackResult;
        bin_ready = 1'b1;
        @(posedge clk); #1;
        bin_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (seg_ready !== 1'b0) begin errors++; $display("[TB] FAIL resetSegReady: got %b, required 0", seg_ready); end
        checks++;
        if (bin_valid !== 1'b0) begin errors++; $display("[TB] FAIL resetBinValid: got %b, required 0", bin_valid); end
        checks++;
        if (bin !== 8'h00) begin errors++; $display("[TB] FAIL resetBin: got %h, required 00", bin); end
        checks++;
        if ({err_code, err_range} !== 2'b00) begin errors++; $display("[TB] FAIL resetErr: got %b%b, required 00", err_code, err_range); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (seg_ready !== 1'b0) begin errors++; $display("[TB] FAIL readyBeforeEdge: got %b, required 0", seg_ready); end
        @(posedge clk); #1;
        checks++;
        if (seg_ready !== 1'b1) begin errors++; $display("[TB] FAIL readyAfterEdge: got %b, required 1", seg_ready); end
    endtask

    task automatic test_max_value;
        int w;
        vec = '{7'h5B, 7'h6D, 7'h6D, 7'h00};
        sendNumber(3);
        checks++;
        if (bin_valid !== 1'b0 || seg_ready !== 1'b0) begin errors++; $display("[TB] FAIL lastEdge: bin_valid=%b seg_ready=%b, required 0 0", bin_valid, seg_ready); end
        waitValid(w);
        checks++;
        if (w != 1) begin errors++; $display("[TB] FAIL latency: got %0d cycles, required 1", w); end
        checks++;
        if (bin !== 8'd255) begin errors++; $display("[TB] FAIL max255: got %0d, required 255", bin); end
        checks++;
        if ({err_code, err_range} !== 2'b00) begin errors++; $display("[TB] FAIL max255Err: got %b%b, required 00", err_code, err_range); end
        ackResult();
        checks++;
        if (bin_valid !== 1'b0) begin errors++; $display("[TB] FAIL maxAck: bin_valid=%b, required 0", bin_valid); end
    endtask

    task automatic test_range;
        int w;
        vec = '{7'h5B, 7'h6D, 7'h7D, 7'h00};
        sendNumber(3);
        waitValid(w);
        checks++;
        if (w != 1 || bin !== 8'h00 || err_range !== 1'b1 || err_code !== 1'b0) begin
            errors++; $display("[TB] FAIL range256: w=%0d bin=%h rng=%b code=%b, required 1 00 1 0", w, bin, err_range, err_code);
        end
        ackResult();
        vec = '{7'h3F, 7'h3F, 7'h3F, 7'h06};
        sendNumber(4);
        waitValid(w);
        checks++;
        if (w != 1 || bin !== 8'h00 || err_range !== 1'b1 || err_code !== 1'b0) begin
            errors++; $display("[TB] FAIL range4dig: w=%0d bin=%h rng=%b code=%b, required 1 00 1 0", w, bin, err_range, err_code);
        end
        ackResult();
        vec = '{7'h6F, 7'h6F, 7'h6F, 7'h6F};
        sendNumber(4);
        waitValid(w);
        checks++;
        if (w != 1 || bin !== 8'h00 || err_range !== 1'b1 || err_code !== 1'b0) begin
            errors++; $display("[TB] FAIL range9999: w=%0d bin=%h rng=%b code=%b, required 1 00 1 0", w, bin, err_range, err_code);
        end
        ackResult();
    endtask

    task automatic test_blank_code;
        int w;
        vec = '{7'h00, 7'h00, 7'h07, 7'h00};
        sendNumber(3);
        waitValid(w);
        checks++;
        if (w != 1 || bin !== 8'd7 || err_range !== 1'b0 || err_code !== 1'b0) begin
            errors++; $display("[TB] FAIL leadBlank: w=%0d bin=%h rng=%b code=%b, required 1 07 0 0", w, bin, err_range, err_code);
        end
        ackResult();
        vec = '{7'h06, 7'h00, 7'h00, 7'h00};
        sendNumber(2);
        waitValid(w);
        checks++;
        if (w != 1 || bin !== 8'h00 || err_range !== 1'b0 || err_code !== 1'b1) begin
            errors++; $display("[TB] FAIL trailBlank: w=%0d bin=%h rng=%b code=%b, required 1 00 0 1", w, bin, err_range, err_code);
        end
        ackResult();
        vec = '{7'h49, 7'h00, 7'h00, 7'h00};
        sendNumber(1);
        waitValid(w);
        checks++;
        if (w != 1 || bin !== 8'h00 || err_range !== 1'b0 || err_code !== 1'b1) begin
            errors++; $display("[TB] FAIL badPattern: w=%0d bin=%h rng=%b code=%b, required 1 00 0 1", w, bin, err_range, err_code);
        end
        ackResult();
    endtask

    task automatic test_backpressure;
        int w;
        sendDigit(7'h06, 1'b1);
        waitValid(w);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bin !== 8'd1 || bin_valid !== 1'b1 || seg_ready !== 1'b0 || err_code !== 1'b0 || err_range !== 1'b0) begin
                errors++; $display("[TB] FAIL hold%0d: bin=%h valid=%b ready=%b code=%b rng=%b, required 01 1 0 0 0", c, bin, bin_valid, seg_ready, err_code, err_range);
            end
            @(posedge clk); #1;
        end
        bin_ready = 1'b1;
        #2;
        checks++;
        if (seg_ready !== 1'b0) begin errors++; $display("[TB] FAIL ackCycleReady: got %b, required 0", seg_ready); end
        @(posedge clk); #1;
        bin_ready = 1'b0;
        checks++;
        if (seg_ready !== 1'b1 || bin_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL afterAck: ready=%b valid=%b, required 1 0", seg_ready, bin_valid);
        end
    endtask

    task automatic test_reset_mid;
        int w;
        sendDigit(7'h4F, 1'b0);
        rst_n = 1'b0;
        #2;
        checks++;
        if (bin !== 8'h00 || bin_valid !== 1'b0 || seg_ready !== 1'b0 || err_code !== 1'b0 || err_range !== 1'b0) begin
            errors++; $display("[TB] FAIL midReset: bin=%h valid=%b ready=%b, required 00 0 0", bin, bin_valid, seg_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        sendDigit(7'h07, 1'b1);
        waitValid(w);
        checks++;
        if (w != 1 || bin !== 8'd7 || err_code !== 1'b0 || err_range !== 1'b0) begin
            errors++; $display("[TB] FAIL noResidue: w=%0d bin=%h code=%b rng=%b, required 1 07 0 0", w, bin, err_code, err_range);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (bin_valid !== 1'b0 || bin !== 8'h00) begin
            errors++; $display("[TB] FAIL doneReset: valid=%b bin=%h, required 0 00", bin_valid, bin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (seg_ready !== 1'b1 || bin_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL postReset: ready=%b valid=%b, required 1 0", seg_ready, bin_valid);
        end
    endtask

    task automatic test_back_to_back;
        int w;
        sendDigit(7'h4F, 1'b1);
        waitValid(w);
        checks++;
        if (w != 1 || bin !== 8'd3) begin errors++; $display("[TB] FAIL b2bFirst: w=%0d bin=%h, required 1 03", w, bin); end
        ackResult();
        vec = '{7'h6D, 7'h3F, 7'h00, 7'h00};
        sendNumber(2);
        waitValid(w);
        checks++;
        if (w != 1 || bin !== 8'd50 || err_code !== 1'b0 || err_range !== 1'b0) begin
            errors++; $display("[TB] FAIL b2bSecond: w=%0d bin=%0d, required 1 50", w, bin);
        end
        ackResult();
    endtask

    task automatic test_random;
        int w;
        int val;
        int nd;
        int expBin;
        logic expRange;
        int results;
        results = 0;
        gapMax = 2;
        for (int n = 0; n < 25; n++) begin
            val = int'($urandom_range(0, 999));
            nd  = (val >= 100) ? 3 : ((val >= 10) ? 2 : 1);
            if (nd == 3) begin
                vec[0] = segTab[val / 100];
                vec[1] = segTab[(val / 10) % 10];
                vec[2] = segTab[val % 10];
            end else if (nd == 2) begin
                vec[0] = segTab[val / 10];
                vec[1] = segTab[val % 10];
            end else begin
                vec[0] = segTab[val];
            end
            expRange = (val > 255);
            expBin   = expRange ? 0 : val;
            sendNumber(nd);
            waitValid(w);
            if (bin_valid === 1'b1) results++;
            checks++;
            if (w != 1) begin errors++; $display("[TB] FAIL rndLatency%0d: got %0d, required 1", n, w); end
            checks++;
            if (bin !== 8'(expBin) || err_range !== expRange || err_code !== 1'b0) begin
                errors++; $display("[TB] FAIL rndValue%0d: val=%0d bin=%0d rng=%b code=%b, required %0d %b 0", n, val, bin, err_range, err_code, expBin, expRange);
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            checks++;
            if (bin_valid !== 1'b1 || bin !== 8'(expBin)) begin
                errors++; $display("[TB] FAIL rndHold%0d: valid=%b bin=%0d, required 1 %0d", n, bin_valid, bin, expBin);
            end
            ackResult();
            checks++;
            if (bin_valid !== 1'b0) begin errors++; $display("[TB] FAIL rndDup%0d: valid=%b, required 0", n, bin_valid); end
        end
        checks++;
        if (results != 25) begin errors++; $display("[TB] FAIL rndCount: got %0d results, required 25", results); end
        gapMax = 0;
    endtask

    initial begin
        $display("[TB] starting seg_to_binary_encoder bench");
        test_reset();
        test_max_value();
        test_range();
        test_blank_code();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
